// File: rtl/bcd_scan_pkg.sv
// Shared types and constants for the 4-digit BCD scan counter.
// Imported by bcd_digit_cell and bcd_scan_counter.
package bcd_scan_pkg;

    localparam int NUM_DIGITS = 4;

    typedef logic [3:0] bcd_t;

    localparam bcd_t       BCD_MAX = 4'd9;
    localparam logic [3:0] SEL_OFF = 4'b1111;

    // Active-low select pattern for one scan slot.
    function automatic logic [3:0] sel_onehot(
        input logic [1:0] idx
    );
        logic [3:0] s;
        s = SEL_OFF;
        unique case (idx)
            2'd0: s = 4'b1110;
            2'd1: s = 4'b1101;
            2'd2: s = 4'b1011;
            2'd3: s = 4'b0111;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One decade of the BCD counter chain.
// cout asserts when this digit rolls 9 -> 0 on an incoming carry.
module bcd_digit_cell
    import bcd_scan_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic cin,
    output bcd_t q,
    output logic cout
);

    assign cout = cin & (q == BCD_MAX);

    // Digit register: reset and clear win over the carry-in.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (cin) begin
            q <= (q == BCD_MAX) ? '0 : q + 4'd1;
        end
    end

endmodule

// File: rtl/bcd_scan_counter.sv
// 4-digit BCD event counter with multiplexed display scan.
// Define BCD_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module bcd_scan_counter
    import bcd_scan_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] hex,
    output logic [3:0] digit_sel,
    output logic       carry
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);

    logic [PW-1:0]         presc;
    logic [1:0]            scan_idx;
    bcd_t                  digits [NUM_DIGITS];
    logic [NUM_DIGITS:0]   chain;
    logic [NUM_DIGITS-1:0] blank;
    bcd_t                  hex_nxt;
    logic [3:0]            sel_nxt;

    assign chain[0] = inc;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
        bcd_digit_cell u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clr),
            .cin   (chain[i]),
            .q     (digits[i]),
            .cout  (chain[i+1])
        );
    end

`ifdef BCD_LEADING_ZERO_BLANK_EN
    // Blank digit i when it and every higher digit are zero.
    always_comb begin
        logic zero_above;
        blank      = '0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above & (digits[i] == 4'd0);
            blank[i]   = zero_above;
        end
    end
`else
    // Every digit is always shown.
    always_comb begin
        blank = '0;
    end
`endif

    // Select the digit and enable for the current scan slot.
    always_comb begin
        hex_nxt = digits[scan_idx];
        sel_nxt = sel_onehot(scan_idx);
        if (blank[scan_idx]) begin
            hex_nxt = '0;
            sel_nxt = SEL_OFF;
        end
    end

    // Prescaler paces the scan; slot index wraps 3 -> 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc    <= '0;
            scan_idx <= '0;
        end else if (presc == PRE_LAST) begin
            presc    <= '0;
            scan_idx <= scan_idx + 2'd1;
        end else begin
            presc    <= presc + 1'b1;
        end
    end

    // Registered display outputs, one cycle behind slot/digits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hex       <= '0;
            digit_sel <= SEL_OFF;
        end else begin
            hex       <= hex_nxt;
            digit_sel <= sel_nxt;
        end
    end

    // Wrap pulse: carry out of the top digit, suppressed by clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            carry <= 1'b0;
        end else if (clr) begin
            carry <= 1'b0;
        end else begin
            carry <= chain[NUM_DIGITS];
        end
    end

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Directed bench for bcd_scan_counter with SCAN_DIV=4.
// Blank expectations follow BCD_LEADING_ZERO_BLANK_EN.
module tb_bcd_scan_counter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       inc = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] hex;
    logic [3:0] digit_sel;
    logic       carry;

    int checks = 0;
    int errors = 0;

    bcd_scan_counter #(.SCAN_DIV(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (inc),
        .clr       (clr),
        .hex       (hex),
        .digit_sel (digit_sel),
        .carry     (carry)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int n, output bit saw);
        saw = 1'b0;
        inc = 1'b1;
        repeat (n) begin
            tick();
            if (carry) saw = 1'b1;
        end
        inc = 1'b0;
    endtask

    task automatic do_clear;
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    // Assemble the displayed count over one full scan.
    task automatic read_count(output logic [15:0] v);
        v = '0;
        tick();
        repeat (16) begin
            tick();
            case (digit_sel)
                4'b1110: v[3:0]   = hex;
                4'b1101: v[7:4]   = hex;
                4'b1011: v[11:8]  = hex;
                4'b0111: v[15:12] = hex;
                default: ;
            endcase
        end
    endtask

    // Advance to the first cycle of slot 0.
    task automatic align(output bit ok);
        logic [3:0] prev;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            prev = digit_sel;
            tick();
            if (digit_sel == 4'b1110 && prev != 4'b1110) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL align: slot 0 not found, sel=%b", digit_sel);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        inc   = 1'b1;
        tick();
        tick();
        checks++;
        if (hex !== 4'd0) begin
            errors++;
            $display("FAIL rst_hex got=%h exp=0", hex);
        end
        checks++;
        if (digit_sel !== 4'b1111) begin
            errors++;
            $display("FAIL rst_sel got=%b exp=1111", digit_sel);
        end
        checks++;
        if (carry !== 1'b0) begin
            errors++;
            $display("FAIL rst_carry got=%b exp=0", carry);
        end
        rst_n = 1'b1;
        inc   = 1'b0;
        tick();
        checks++;
        if (digit_sel !== 4'b1110) begin
            errors++;
            $display("FAIL rel_sel got=%b exp=1110", digit_sel);
        end
        checks++;
        if (hex !== 4'd0) begin
            errors++;
            $display("FAIL rel_hex got=%h exp=0", hex);
        end
    endtask

    task automatic test_ripple;
        bit          saw;
        bit          any;
        logic [15:0] v;
        do_clear();
        pulse(10, saw);
        any = saw;
        read_count(v);
        checks++;
        if (v !== 16'h0010) begin
            errors++;
            $display("FAIL ripple10 got=%h exp=0010", v);
        end
        pulse(90, saw);
        any = any | saw;
        read_count(v);
        checks++;
        if (v !== 16'h0100) begin
            errors++;
            $display("FAIL ripple100 got=%h exp=0100", v);
        end
        checks++;
        if (any) begin
            errors++;
            $display("FAIL ripple_carry got=1 exp=0");
        end
    endtask

    task automatic test_wrap;
        bit          saw;
        logic [15:0] v;
        do_clear();
        pulse(9999, saw);
        checks++;
        if (saw) begin
            errors++;
            $display("FAIL wrap_early_carry got=1 exp=0");
        end
        read_count(v);
        checks++;
        if (v !== 16'h9999) begin
            errors++;
            $display("FAIL wrap_load got=%h exp=9999", v);
        end
        inc = 1'b1;
        tick();
        inc = 1'b0;
        checks++;
        if (carry !== 1'b1) begin
            errors++;
            $display("FAIL wrap_carry got=%b exp=1", carry);
        end
        tick();
        checks++;
        if (carry !== 1'b0) begin
            errors++;
            $display("FAIL wrap_carry_end got=%b exp=0", carry);
        end
        read_count(v);
        checks++;
        if (v !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_value got=%h exp=0000", v);
        end
    endtask

    task automatic test_priority;
        bit          saw;
        logic [15:0] v;
        do_clear();
        pulse(5, saw);
        clr = 1'b1;
        inc = 1'b1;
        tick();
        clr = 1'b0;
        inc = 1'b0;
        checks++;
        if (carry !== 1'b0) begin
            errors++;
            $display("FAIL clr_carry got=%b exp=0", carry);
        end
        read_count(v);
        checks++;
        if (v !== 16'h0000) begin
            errors++;
            $display("FAIL clr_value got=%h exp=0000", v);
        end
        pulse(7, saw);
        rst_n = 1'b0;
        inc   = 1'b1;
        tick();
        checks++;
        if (digit_sel !== 4'b1111) begin
            errors++;
            $display("FAIL rst_mid_sel got=%b exp=1111", digit_sel);
        end
        checks++;
        if (hex !== 4'd0) begin
            errors++;
            $display("FAIL rst_mid_hex got=%h exp=0", hex);
        end
        rst_n = 1'b1;
        inc   = 1'b0;
        read_count(v);
        checks++;
        if (v !== 16'h0000) begin
            errors++;
            $display("FAIL rst_mid_value got=%h exp=0000", v);
        end
    endtask

    task automatic test_scan;
        bit         saw;
        bit         ok;
        logic [3:0] es [5];
        logic [3:0] eh [5];
        es = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
        eh = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd4};
        do_clear();
        pulse(1234, saw);
        align(ok);
        if (ok) begin
            for (int s = 0; s < 5; s++) begin
                for (int c = 0; c < 4; c++) begin
                    checks++;
                    if (digit_sel !== es[s] || hex !== eh[s]) begin
                        errors++;
                        $display("FAIL scan s%0d c%0d got=%b/%h exp=%b/%h",
                                 s, c, digit_sel, hex, es[s], eh[s]);
                    end
                    tick();
                end
            end
        end
    endtask

    task automatic test_blank;
        bit         saw;
        bit         ok;
        logic [3:0] es [4];
        logic [3:0] eh [4];
`ifdef BCD_LEADING_ZERO_BLANK_EN
        es = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
`else
        es = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
`endif
        eh = '{4'd2, 4'd4, 4'd0, 4'd0};
        do_clear();
        pulse(42, saw);
        align(ok);
        if (ok) begin
            for (int s = 0; s < 4; s++) begin
                checks++;
                if (digit_sel !== es[s] || hex !== eh[s]) begin
                    errors++;
                    $display("FAIL blank42 s%0d got=%b/%h exp=%b/%h",
                             s, digit_sel, hex, es[s], eh[s]);
                end
                repeat (4) tick();
            end
        end
        do_clear();
`ifdef BCD_LEADING_ZERO_BLANK_EN
        es = '{4'b1110, 4'b1111, 4'b1111, 4'b1111};
`endif
        align(ok);
        if (ok) begin
            for (int s = 0; s < 4; s++) begin
                checks++;
                if (digit_sel !== es[s] || hex !== 4'd0) begin
                    errors++;
                    $display("FAIL blank0 s%0d got=%b/%h exp=%b/0",
                             s, digit_sel, hex, es[s]);
                end
                repeat (4) tick();
            end
        end
    endtask

    initial begin
        test_reset();
        test_ripple();
        test_wrap();
        test_priority();
        test_scan();
        test_blank();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
